// File: rtl/spi_fram_ctrl.sv
// Word-wise SPI (mode 0) master for serial FRAM: WREN, CMD, ADDR, DATA per access.
// Optional build macro FRAM_WRDI_EN appends a WRDI transaction after every write.
module spi_fram_ctrl #(
  parameter int DATA_BYTES  = 2,
  parameter int ADDR_BYTES  = 2,
  parameter int WORD_ADDR_W = 15,
  parameter int CLK_DIV     = 4,
  parameter int CS_GAP      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    we,
  input  logic [WORD_ADDR_W-1:0]  addr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    spi_sck,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic                    spi_cs,
  output logic [3:0]              dbg_state
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int AW = 8 * ADDR_BYTES;
  localparam int SH = $clog2(DATA_BYTES);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_GAP1, S_CMD, S_ADDR, S_DATA, S_END, S_GAP2, S_DONE, S_WRDI, S_GAP3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            sck_q, sck_d, cs_q, cs_d, mosi_q, mosi_d;
  logic            busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [DW-1:0]   rdata_q, rdata_d, rx_q, rx_d, wdata_q, wdata_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     cur_bits;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = we_q;
    rdata_d = rdata_q;
    rx_d    = rx_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;

    cur_bits = '0;
    case (state_q)
      S_WREN:  cur_bits = 32'h06;
      S_CMD:   cur_bits = we_q ? 32'h02 : 32'h03;
      S_ADDR:  cur_bits = 32'(addr_q);
      S_DATA:  cur_bits = we_q ? 32'(wdata_q) : 32'h0;
      S_WRDI:  cur_bits = 32'h04;
      default: cur_bits = '0;
    endcase

    // Every opcode has a clear MSB, so a new transaction always opens with MOSI low.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          we_d    = we;
          addr_d  = AW'(64'(addr) << SH);
          wdata_d = wdata;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = 5'd7;
          mosi_d  = 1'b0;
          state_d = we ? S_WREN : S_CMD;
        end
      end
      S_GAP1: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_CMD;
          cs_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = 5'd7;
          mosi_d  = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_END: begin
        if (!we_q) rdata_d = rx_q;
        gap_d   = '0;
        state_d = S_GAP2;
      end
      S_GAP2: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
`ifdef FRAM_WRDI_EN
          if (we_q) begin
            state_d = S_WRDI;
            done_d  = 1'b0;
            cs_d    = 1'b0;
            cnt_d   = '0;
            bit_d   = 5'd7;
            mosi_d  = 1'b0;
          end
`endif
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_GAP3: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_WREN, S_CMD, S_ADDR, S_DATA, S_WRDI: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            if (state_q == S_DATA && !we_q) rx_d = {rx_q[DW-2:0], spi_miso};
          end else begin
            sck_d = 1'b0;
            if (bit_q != 5'd0) begin
              bit_d  = bit_q - 1'b1;
              mosi_d = cur_bits[bit_q - 5'd1];
            end else begin
              case (state_q)
                S_CMD: begin
                  state_d = S_ADDR;
                  bit_d   = 5'(AW - 1);
                  mosi_d  = addr_q[AW-1];
                end
                S_ADDR: begin
                  state_d = S_DATA;
                  bit_d   = 5'(DW - 1);
                  mosi_d  = we_q & wdata_q[DW-1];
                end
                S_WREN: begin
                  state_d = S_GAP1;
                  cs_d    = 1'b1;
                  mosi_d  = 1'b0;
                  gap_d   = '0;
                end
                S_DATA: begin
                  state_d = S_END;
                  cs_d    = 1'b1;
                  mosi_d  = 1'b0;
                end
                default: begin
                  state_d = S_GAP3;
                  cs_d    = 1'b1;
                  mosi_d  = 1'b0;
                  gap_d   = '0;
                end
              endcase
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      rx_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      rx_q    <= rx_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs    = cs_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_spi_fram_ctrl.sv
// Directed bench for spi_fram_ctrl: default instance plus a 4-byte/3-address/CLK_DIV=1 instance,
// each attached to a behavioural FRAM model.
module tb_spi_fram_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0, we = 1'b0;
  logic [14:0] addr = '0;
  logic [15:0] wdata_a = '0, rdata_a;
  logic [31:0] wdata_b = '0, rdata_b;
  logic        busy_a, done_a, sck_a, mosi_a, cs_a, miso_a = 1'b0;
  logic        busy_b, done_b, sck_b, mosi_b, cs_b, miso_b = 1'b0;
  logic [3:0]  dbg_a, dbg_b;

  spi_fram_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .we(we), .addr(addr), .wdata(wdata_a),
    .rdata(rdata_a), .busy(busy_a), .done(done_a), .spi_sck(sck_a), .spi_mosi(mosi_a),
    .spi_miso(miso_a), .spi_cs(cs_a), .dbg_state(dbg_a)
  );

  spi_fram_ctrl #(.DATA_BYTES(4), .ADDR_BYTES(3), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .we(we), .addr(addr), .wdata(wdata_b),
    .rdata(rdata_b), .busy(busy_b), .done(done_b), .spi_sck(sck_b), .spi_mosi(mosi_b),
    .spi_miso(miso_b), .spi_cs(cs_b), .dbg_state(dbg_b)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // FRAM model A: 2 address bytes, honours WREN/WRDI, clears WEL after a write.
  logic [7:0]  mem_a [0:1023];
  logic [7:0]  bytes_a[$];
  logic [7:0]  sh_a = '0, op_a = '0, rb_a;
  logic [15:0] fa_a = '0;
  logic        wel_a = 1'b0;
  int          nbits_a = 0, txn_a = 0, pos_a;
  always @(negedge cs_a) begin nbits_a = 0; fa_a = '0; op_a = '0; txn_a++; end
  always @(posedge cs_a) if (op_a == 8'h02) wel_a = 1'b0;
  always @(posedge sck_a) if (!cs_a) begin
    sh_a = {sh_a[6:0], mosi_a};
    nbits_a++;
    if (nbits_a % 8 == 0) begin
      bytes_a.push_back(sh_a);
      if (nbits_a == 8) begin
        op_a = sh_a;
        if (sh_a == 8'h06) wel_a = 1'b1;
        if (sh_a == 8'h04) wel_a = 1'b0;
      end else if (nbits_a <= 24) begin
        fa_a = {fa_a[7:0], sh_a};
      end else if (op_a == 8'h02 && wel_a) begin
        mem_a[fa_a[9:0]] = sh_a;
        fa_a = fa_a + 16'd1;
      end
    end
  end
  always @(negedge sck_a) if (!cs_a && op_a == 8'h03 && nbits_a >= 24) begin
    pos_a  = nbits_a - 24;
    rb_a   = mem_a[10'(fa_a + 16'(pos_a / 8))];
    miso_a = rb_a[3'(7 - pos_a % 8)];
  end

  // FRAM model B: 3 address bytes, read-only use.
  logic [7:0]  mem_b [0:255];
  logic [7:0]  bytes_b[$];
  logic [7:0]  sh_b = '0, op_b = '0, rb_b;
  logic [23:0] fa_b = '0;
  int          nbits_b = 0, pos_b;
  always @(negedge cs_b) begin nbits_b = 0; fa_b = '0; op_b = '0; end
  always @(posedge sck_b) if (!cs_b) begin
    sh_b = {sh_b[6:0], mosi_b};
    nbits_b++;
    if (nbits_b % 8 == 0) begin
      bytes_b.push_back(sh_b);
      if (nbits_b == 8) op_b = sh_b;
      else if (nbits_b <= 32) fa_b = {fa_b[15:0], sh_b};
    end
  end
  always @(negedge sck_b) if (!cs_b && op_b == 8'h03 && nbits_b >= 32) begin
    pos_b  = nbits_b - 32;
    rb_b   = mem_b[8'(fa_b + 24'(pos_b / 8))];
    miso_b = rb_b[3'(7 - pos_b % 8)];
  end

  // Bus monitors: CS-low cycles, done pulses, CS-high runs inside a busy access.
  int cslow_a = 0, cslow_b = 0, done_cnt_a = 0, hrun_a = 0;
  int gaps_a[$];
  always @(negedge clk) begin
    if (!cs_a) cslow_a++;
    if (!cs_b) cslow_b++;
    if (done_a) done_cnt_a++;
    if (cs_a && busy_a) hrun_a++;
    else begin
      if (!cs_a && hrun_a > 0) gaps_a.push_back(hrun_a);
      hrun_a = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input bit sel_b, input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      tick();
      got = sel_b ? done_b : done_a;
    end
  endtask

  task automatic clear_a();
    bytes_a.delete();
    gaps_a.delete();
    cslow_a = 0;
    done_cnt_a = 0;
  endtask

  bit got;
  int t0;

  initial begin
    // Reset held with start asserted.
    #1 rst_n = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_cs", cs_a, 1'b1);
      check("rst_sck", sck_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_rdata", rdata_a, 32'h0);
      check("rst_cs_b", cs_b, 1'b1);
      check("rst_busy_b", busy_b, 1'b0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Read of word 0x0012 -> bytes 0x24/0x25.
    mem_a[10'h024] = 8'hAB;
    mem_a[10'h025] = 8'hCD;
    clear_a();
    t0 = txn_a;
    addr = 15'h0012; we = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("rd_busy_after_start", busy_a, 1'b1);
    wait_done(1'b0, 1000, got);
    check("rd_done_seen", got, 1'b1);
    check("rd_rdata", rdata_a, 32'hABCD);
    check("rd_busy_in_done", busy_a, 1'b1);
    check("rd_cs_low_cycles", cslow_a, 320);
    check("rd_nbytes", bytes_a.size(), 5);
    check("rd_op", bytes_a[0], 8'h03);
    check("rd_addr_hi", bytes_a[1], 8'h00);
    check("rd_addr_lo", bytes_a[2], 8'h24);
    check("rd_txns", txn_a - t0, 1);
    tick();
    check("rd_done_pulse", done_a, 1'b0);
    check("rd_busy_drop", busy_a, 1'b0);
    check("rd_done_count", done_cnt_a, 1);

    // Second start while busy must be ignored.
    mem_a[10'h026] = 8'h5A;
    mem_a[10'h027] = 8'hC3;
    clear_a();
    t0 = txn_a;
    addr = 15'h0013; we = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (50) tick();
    addr = 15'h0012; we = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(1'b0, 1000, got);
    check("dbl_done_seen", got, 1'b1);
    check("dbl_rdata", rdata_a, 32'h5AC3);
    check("dbl_addr_lo", bytes_a[2], 8'h26);
    repeat (30) tick();
    check("dbl_txns", txn_a - t0, 1);
    check("dbl_done_count", done_cnt_a, 1);
    check("dbl_idle", busy_a, 1'b0);

    // Write 0x1234 to word 0x0100 -> bytes 0x200/0x201.
    clear_a();
    t0 = txn_a;
    addr = 15'h0100; we = 1'b1; wdata_a = 16'h1234; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    we = 1'b0;
    wdata_a = 16'hFFFF;
    wait_done(1'b0, 2000, got);
    check("wr_done_seen", got, 1'b1);
    check("wr_wren", bytes_a[0], 8'h06);
    check("wr_op", bytes_a[1], 8'h02);
    check("wr_addr_hi", bytes_a[2], 8'h02);
    check("wr_addr_lo", bytes_a[3], 8'h00);
    check("wr_d0", bytes_a[4], 8'h12);
    check("wr_d1", bytes_a[5], 8'h34);
    check("wr_mem_200", mem_a[10'h200], 8'h12);
    check("wr_mem_201", mem_a[10'h201], 8'h34);
    check("wr_rdata_kept", rdata_a, 32'h5AC3);
    check("wr_gap1_exact", gaps_a[0], 8);
`ifdef FRAM_WRDI_EN
    check("wr_nbytes", bytes_a.size(), 7);
    check("wr_wrdi", bytes_a[6], 8'h04);
    check("wr_txns", txn_a - t0, 3);
    check("wr_ngaps", gaps_a.size(), 2);
    check("wr_gap2_ge", gaps_a[1] >= 8, 1'b1);
`else
    check("wr_nbytes", bytes_a.size(), 6);
    check("wr_txns", txn_a - t0, 2);
    check("wr_ngaps", gaps_a.size(), 1);
`endif
    tick();
    check("wr_done_pulse", done_a, 1'b0);
    check("wr_done_count", done_cnt_a, 1);

    // Write 0x00FF to word 0x0101 -> bytes 0x202/0x203.
    clear_a();
    t0 = txn_a;
    addr = 15'h0101; we = 1'b1; wdata_a = 16'h00FF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(1'b0, 2000, got);
    check("wr2_done_seen", got, 1'b1);
    check("wr2_mem_202", mem_a[10'h202], 8'h00);
    check("wr2_mem_203", mem_a[10'h203], 8'hFF);
    check("wr2_wel_clear", wel_a, 1'b0);
`ifdef FRAM_WRDI_EN
    check("wr2_wrdi", bytes_a[6], 8'h04);
    check("wr2_txns_before_done", txn_a - t0, 3);
`else
    check("wr2_txns", txn_a - t0, 2);
`endif

    // Wide instance: 4 data bytes, 3 address bytes, CLK_DIV=1, word 3 -> byte 0x0C.
    mem_b[8'h0C] = 8'h01;
    mem_b[8'h0D] = 8'h02;
    mem_b[8'h0E] = 8'h03;
    mem_b[8'h0F] = 8'h04;
    bytes_b.delete();
    cslow_b = 0;
    addr = 15'h0003; we = 1'b0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done(1'b1, 1000, got);
    check("b_done_seen", got, 1'b1);
    check("b_rdata", rdata_b, 32'h01020304);
    check("b_op", bytes_b[0], 8'h03);
    check("b_addr2", bytes_b[1], 8'h00);
    check("b_addr1", bytes_b[2], 8'h00);
    check("b_addr0", bytes_b[3], 8'h0C);
    check("b_cs_low_cycles", cslow_b, 128);

    // Reset during the DATA phase of a read (DATA spans cycles 192..319).
    clear_a();
    addr = 15'h0012; we = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (220) tick();
    check("mid_cs_low_before", cs_a, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_cs_now_high", cs_a, 1'b1);
    check("mid_sck_low", sck_a, 1'b0);
    check("mid_busy", busy_a, 1'b0);
    check("mid_rdata", rdata_a, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_a();
    addr = 15'h0012; we = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(1'b0, 1000, got);
    check("post_done_seen", got, 1'b1);
    check("post_rdata", rdata_a, 32'hABCD);
    check("post_cs_low_cycles", cslow_a, 320);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_fram_ctrl.md
Name: spi_fram_ctrl

Overview:
Parametrised SPI master for serial FRAM devices, accessed word-wise by the CPU datapath. Each word access is one SPI transaction: command, address, then DATA_BYTES data bytes. The FRAM's internal address auto-increment carries the transfer from byte to byte. Write accesses are preceded by a WREN transaction. SCK rate, word width and address width are configurable. The block replaces the fixed 16-bit, byte-per-transaction FRAM interface used by the CPU core.

Parameters:
DATA_BYTES, 2, bytes per word (1, 2, 4; power of two).
ADDR_BYTES, 2, address bytes sent after command (2 or 3).
WORD_ADDR_W, 15, width of word address input.
CLK_DIV, 4, clk cycles per SCK half-period (>=1).
CS_GAP, 8, minimum clk cycles of CS high between transactions.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request strobe, sampled only in IDLE
we  in  1  1 = write, 0 = read; sampled with start
addr  in  WORD_ADDR_W  word address
wdata  in  8*DATA_BYTES  write word
rdata  out  8*DATA_BYTES  read word; valid from done until next read completes
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cycle pulse on completion
spi_sck  out  1  serial clock, mode 0 (idle low)
spi_mosi  out  1  serial data out
spi_miso  in  1  serial data in
spi_cs  out  1  chip select, active low

Behaviour:
- Reset (asynchronous, active-low): spi_cs=1, spi_sck=0, spi_mosi=0, rdata=0, busy=0, done=0, state=IDLE. Asserting reset mid-transaction raises CS immediately; the aborted write may be partial.
- Byte address = addr << log2(DATA_BYTES), zero-extended or truncated to 8*ADDR_BYTES bits, sent MSB first.
- Word byte order is big-endian: wdata/rdata[8*DATA_BYTES-1 -: 8] sits at the lowest byte address.
- SPI mode 0:
  - MOSI changes while SCK is low, at least CLK_DIV cycles before the rising edge.
  - MISO is sampled on the clk edge that drives SCK high.
  - Every bit is one SCK low phase plus one high phase, each CLK_DIV cycles long.
  - SCK returns low after the final bit, before CS rises.
- States: IDLE, WREN, GAP1, CMD, ADDR, DATA, END, GAP2, DONE.
  - IDLE: on start, latch we/addr/wdata and set busy. Next state is WREN if we=1, else CMD.
  - WREN: CS low, shift 8'h06; then CS high; go to GAP1.
  - GAP1: hold CS high for CS_GAP cycles; go to CMD.
  - CMD: CS low, shift 8'h02 (write) or 8'h03 (read).
  - ADDR: shift 8*ADDR_BYTES address bits.
  - DATA: shift 8*DATA_BYTES bits.
    - Write: bits come from the latched wdata, MSB first.
    - Read: bits are assembled into a shift register. rdata updates only once, at END, so rdata never shows a partial word.
  - END: SCK low, CS high.
  - GAP2: CS_GAP cycles; go to DONE.
  - DONE: one cycle with done=1; busy drops on the following cycle; return to IDLE.
- start while busy is ignored (no queuing). Inputs other than start may change after acceptance.
- Read latency, CS low duration: 2*CLK_DIV*(8+8*ADDR_BYTES+8*DATA_BYTES) cycles.
- No DATA-phase wait states; FRAM needs no write polling.
- rdata is unchanged by write accesses.

Optional Feature:
Macro FRAM_WRDI_EN.
- Defined: after GAP2 of a write access, run one extra transaction: CS low, shift 8'h04 (WRDI), CS high, then CS_GAP cycles, then DONE. The write-enable latch is left cleared after every write.
- Undefined: no WRDI is sent; the write path is WREN, GAP1, CMD, ADDR, DATA, END, GAP2, DONE. Read behaviour is identical in both builds.

Test Plan:
- Defaults; reset asserted with start=1 -> spi_cs=1, spi_sck=0, busy=0, done=0, rdata=0 throughout.
- Read addr=15'h0012, FRAM model holds 0x24=8'hAB and 0x25=8'hCD:
  - MOSI carries 8'h03, 16'h0024;
  - rdata=16'hABCD at done;
  - CS low for exactly 2*4*40=320 cycles;
  - done is a single cycle.
- Write addr=15'h0100, wdata=16'h1234:
  - WREN 8'h06, then CS high for >=8 cycles;
  - then 8'h02, 16'h0200, 8'h12, 8'h34;
  - model memory 0x200=12, 0x201=34;
  - rdata unchanged.
- DATA_BYTES=4, ADDR_BYTES=3, CLK_DIV=1, read addr=15'h0003:
  - address bytes 00 00 0C;
  - model bytes 01 02 03 04 -> rdata=32'h01020304.
- start pulsed again while busy during a read -> ignored; exactly one transaction and one done pulse.
- FRAM_WRDI_EN defined, write wdata=16'h00FF:
  - 8'h04 transaction appears after the data transaction, with CS gaps >=CS_GAP between transactions;
  - done only after WRDI.
- Reset asserted mid-way through the DATA phase -> CS high in the same cycle; next read after reset works normally.
